// File: rtl/pc_fetch_pkg.sv
// Shared encodings for the fetch stage and its npc neighbour.
// Holds the fetch FSM states, the reset PC and the npc select codes.
package pc_fetch_pkg;

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2
  } fetch_state_t;

  // Word address [31:2]; byte address 0x0000_3000.
  localparam logic [29:0] RESET_PC = 30'h0c00;

  typedef enum logic [1:0] {
    NPC_PC4    = 2'd0,
    NPC_BRANCH = 2'd1,
    NPC_JUMP   = 2'd2,
    NPC_JREG   = 2'd3
  } npc_op_t;

  function automatic logic [31:0] word_to_byte(input logic [29:0] word_addr);
    return {word_addr, 2'b00};
  endfunction

endpackage

// File: rtl/pc_fetch_pc_reg.sv
// Program-counter register: 30-bit word address with async reset and load enable.
module pc_reg #(
  parameter logic [29:0] RESET_VAL = pc_fetch_pkg::RESET_PC
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic [29:0] d,
  output logic [29:0] q
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q <= RESET_VAL;
    end else if (load) begin
      q <= d;
    end
  end

endmodule

// File: rtl/pc_fetch.sv
// Fetch stage: issues one imem request per PC, holds the instruction for
// decode/npc and advances the PC on the downstream handshake.
//
//   state  | meaning
//   S_REQ  | request valid at PC, waiting for imem_req_ready
//   S_WAIT | request accepted, waiting for imem_resp_valid
//   S_HOLD | instruction presented, waiting for inst_ready
module pc_fetch #(
  parameter logic [29:0] RESET_PC = pc_fetch_pkg::RESET_PC,
  parameter logic [7:0]  MAX_WAIT = 8'd255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [29:0] npc_in,
  output logic        imem_req_valid,
  output logic [29:0] imem_req_addr,
  input  logic        imem_req_ready,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  output logic        inst_valid,
  output logic [31:0] inst,
  output logic [29:0] pc_out,
  input  logic        inst_ready,
  output logic [31:0] fetch_count,
  output logic        fetch_err
);

  import pc_fetch_pkg::*;

  fetch_state_t state;
  fetch_state_t state_nxt;
  logic [7:0]   wait_cnt;
  logic         pc_load;
  logic         resp_take;
  logic         inst_fire;
  logic         wait_expire;

  pc_reg #(
    .RESET_VAL (RESET_PC)
  ) u_pc_reg (
    .clk   (clk),
    .reset (reset),
    .load  (pc_load),
    .d     (npc_in),
    .q     (pc_out)
  );

  assign imem_req_addr = pc_out;
  assign resp_take     = (state == S_WAIT) && imem_resp_valid;
  assign inst_fire     = inst_valid && inst_ready;
  assign pc_load       = inst_fire;
  assign wait_expire   = (state == S_WAIT) && !imem_resp_valid &&
                         (wait_cnt >= (MAX_WAIT - 8'd1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_REQ;
    end else begin
      state <= state_nxt;
    end
  end

  // Request valid is gated by reset so nothing is offered to memory while it
  // is itself being reset.
  always_comb begin
    state_nxt      = state;
    imem_req_valid = 1'b0;
    inst_valid     = 1'b0;
    case (state)
      S_REQ: begin
        imem_req_valid = !reset;
        if (imem_req_ready && !reset) begin
          state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        if (imem_resp_valid) begin
          state_nxt = S_HOLD;
        end
      end
      S_HOLD: begin
        inst_valid = 1'b1;
        if (inst_ready) begin
          state_nxt = S_REQ;
        end
      end
      default: begin
        state_nxt = S_REQ;
      end
    endcase
  end

  // Counts cycles spent in S_WAIT; saturates so a very late response cannot wrap it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wait_cnt <= 8'd0;
    end else if (state != S_WAIT || imem_resp_valid) begin
      wait_cnt <= 8'd0;
    end else if (wait_cnt != MAX_WAIT) begin
      wait_cnt <= wait_cnt + 8'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_err <= 1'b0;
    end else if (wait_expire) begin
      fetch_err <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      inst <= 32'h0;
    end else if (resp_take) begin
      inst <= imem_resp_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_count <= 32'h0;
    end else if (inst_fire) begin
      fetch_count <= fetch_count + 32'd1;
    end
  end

endmodule

// File: doc/pc_fetch.md
Name: pc_fetch

Overview:
- Program-counter register and instruction-fetch stage that sits directly upstream of npc.
- Holds the current PC (word address [31:2]) and fetches the instruction at PC from instruction memory over a valid/ready request and valid response interface.
- Presents {PC, instruction} to decode/npc, then loads npc's NPC result as the new PC when the downstream stage accepts the instruction.
- Also counts retired fetches and flags memory timeouts.

Parameters:
- RESET_PC, 30'h0c00, word address loaded on reset (byte address 0x0000_3000). Matches npc's default NPC.
- MAX_WAIT, 8'd255, maximum cycles in S_WAIT before fetch_err is set. Legal range 1..255.

Ports:
- clk  input  1  sole clock; all state updates on its rising edge.
- reset  input  1  asynchronous, active-high; clears all state immediately.
- npc_in  input  30  next PC [31:2] from npc; sampled only on the inst handshake.
- imem_req_valid  output  1  fetch request valid.
- imem_req_addr  output  30  word address of the request; always equals pc_out.
- imem_req_ready  input  1  memory accepts the request when high together with imem_req_valid.
- imem_resp_valid  input  1  response data valid; one cycle per accepted request.
- imem_resp_data  input  32  fetched instruction.
- inst_valid  output  1  inst/pc_out are valid for decode/npc.
- inst  output  32  registered instruction.
- pc_out  output  30  current PC [31:2]; feeds npc PC input.
- inst_ready  input  1  downstream consumes the instruction.
- fetch_count  output  32  number of completed inst handshakes since reset; wraps at 2^32.
- fetch_err  output  1  sticky; set when a response does not arrive within MAX_WAIT cycles.

Behaviour:
- Reset (async, any state): PC=RESET_PC, state=S_REQ, inst=32'h0, inst_valid=0, imem_req_valid=0 while reset is asserted, fetch_count=0, fetch_err=0, wait_cnt=0. Instruction memory shares this reset, so no in-flight response survives reset.
- FSM states:
  - S_REQ: imem_req_valid=1, imem_req_addr=PC. Go to S_WAIT on imem_req_valid&&imem_req_ready; otherwise stay with address held stable.
  - S_WAIT: imem_req_valid=0; wait_cnt increments each cycle.
    - On imem_resp_valid: inst<=imem_resp_data, clear wait_cnt, go to S_HOLD.
    - If wait_cnt reaches MAX_WAIT with no response: set fetch_err (sticky) and remain in S_WAIT. A late response is still accepted.
  - S_HOLD: inst_valid=1; inst and pc_out held stable.
    - On inst_ready: PC<=npc_in, fetch_count+=1, go to S_REQ.
    - Without inst_ready: stay (stall) indefinitely.
- Latency: memory accepts in 1 cycle and responds 1 cycle later gives inst_valid 2 cycles after S_REQ entry. Minimum throughput is one instruction per 3 cycles.
- Response in the same cycle as request acceptance is illegal (memory latency ≥1). A response seen in S_REQ or S_HOLD is ignored and does not change inst.
- inst_valid is registered, i.e. asserted only in S_HOLD. It never depends combinationally on inst_ready.
- npc_in is combinational from npc (which uses pc_out and inst). Only its value in the handshake cycle matters. No width conversion: all 30 bits are loaded verbatim, and PC wraps naturally.
- The only path to a new PC is the handshake, so simultaneous inst_ready and stale resp_valid in S_HOLD produce a PC update only.
- fetch_count increments exactly once per handshake and wraps 32'hFFFF_FFFF to 0.
- Reset asserted in S_WAIT or S_HOLD discards the pending instruction. After deassertion, fetching restarts at RESET_PC.

Decomposition:
- Shared package holds state encodings S_REQ=2'd0, S_WAIT=2'd1, S_HOLD=2'd2, the RESET_PC constant 30'h0c00, and the npc jump/branch codes already used by npc.
- One sub-module is natural: pc_reg (30-bit register with async reset to RESET_PC and load enable). The FSM, counters and error flag stay in pc_fetch.

Test Plan:
- Reset release, memory ready=1, 1-cycle response 32'h2008_0005 -> request addr 30'h0c00 in cycle 0; inst_valid in cycle 2 with inst=32'h2008_0005 and pc_out=30'h0c00.
- Handshake with npc_in=30'h0c01, then npc_in=30'h0c02 -> requests at 30'h0c01 and then 30'h0c02; fetch_count=2.
- Hold inst_ready=0 for 5 cycles in S_HOLD, pulsing stray resp_valid with 32'hDEAD_BEEF -> inst, pc_out and inst_valid stay unchanged, with no new request.
- imem_req_ready low for 3 cycles -> imem_req_valid stays high and the address stays stable; transition to S_WAIT occurs only on the ready cycle.
- MAX_WAIT=4 with response delayed 6 cycles -> fetch_err rises after 4 wait cycles, instruction is still captured, and fetch_err stays 1 until reset.
- Assert reset in S_WAIT when PC=30'h0c10 -> immediately inst_valid=0, pc_out=30'h0c00, fetch_count=0, fetch_err=0; after release, first request addr=30'h0c00.
